// File: rtl/lcd_nibble_reader.sv
// rtl/lcd_nibble_reader.sv - HD44780-style 4-bit LCD read sequencer with optional busy-flag polling
module lcd_nibble_reader #(
  parameter int SETUP_CYCLES      = 2,
  parameter int E_HIGH_CYCLES     = 12,
  parameter int NIBBLE_GAP_CYCLES = 50,
  parameter int POLL_LIMIT        = 1000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iRequest,
  input  logic       iRegisterSelect,
  input  logic       iPoll_Busy,
  input  logic [3:0] iLCD_Data,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [7:0] oData,
  output logic       oDone,
  output logic       oBusy,
  output logic       oTimeout
);

  typedef enum logic [2:0] {
    sIdle, sSetup, sEh1, sGap1, sEh2, sGap2, sDone
  } state_t;

  localparam logic [15:0] SetupLen = 16'(SETUP_CYCLES);
  localparam logic [15:0] EHighLen = 16'(E_HIGH_CYCLES);
  localparam logic [15:0] GapLen   = 16'(NIBBLE_GAP_CYCLES);
  localparam logic [15:0] PollMax  = 16'(POLL_LIMIT);

  state_t      state, nextState;
  logic [15:0] phaseCount, pollCount, phaseLen;
  logic        phaseLast, rsLatched, pollLatched, accept, pollAgain;

  assign accept    = (state == sIdle) && iRequest;
  assign phaseLast = (phaseCount == phaseLen - 16'd1);
  // oData[7] holds the busy flag captured from the first nibble of this read
  assign pollAgain = pollLatched && oData[7];

  always_comb begin
    nextState = state;
    phaseLen  = 16'd1;
    case (state)
      sIdle:  if (iRequest) nextState = sSetup;
      sSetup: begin
        phaseLen = SetupLen;
        if (phaseLast) nextState = sEh1;
      end
      sEh1: begin
        phaseLen = EHighLen;
        if (phaseLast) nextState = sGap1;
      end
      sGap1: begin
        phaseLen = GapLen;
        if (phaseLast) nextState = sEh2;
      end
      sEh2: begin
        phaseLen = EHighLen;
        if (phaseLast) nextState = sGap2;
      end
      sGap2: begin
        phaseLen = GapLen;
        if (phaseLast) nextState = (pollAgain && pollCount < PollMax) ? sEh1 : sDone;
      end
      sDone:  nextState = sIdle;
      default: nextState = sIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= sIdle;
      phaseCount  <= 16'd0;
      pollCount   <= 16'd0;
      rsLatched   <= 1'b0;
      pollLatched <= 1'b0;
      oData       <= 8'h00;
      oTimeout    <= 1'b0;
    end else begin
      state      <= nextState;
      phaseCount <= (nextState != state) ? 16'd0 : phaseCount + 16'd1;
      if (accept) begin
        rsLatched   <= iRegisterSelect && !iPoll_Busy;
        pollLatched <= iPoll_Busy;
        pollCount   <= 16'd0;
        oTimeout    <= 1'b0;
      end
      if (state == sEh1 && phaseLast) oData[7:4] <= iLCD_Data;
      if (state == sEh2 && phaseLast) oData[3:0] <= iLCD_Data;
      if (nextState == sGap2 && state != sGap2 && pollCount < PollMax)
        pollCount <= pollCount + 16'd1;
      if (state == sGap2 && phaseLast && pollAgain && pollCount == PollMax)
        oTimeout <= 1'b1;
    end
  end

  // Every pin is decoded from registered state, so E cannot glitch
  assign oLCD_Enabled            = (state == sEh1) || (state == sEh2);
  assign oLCD_ReadWrite          = (state != sIdle) && (state != sDone);
  assign oLCD_RegisterSelect     = oLCD_ReadWrite && rsLatched;
  assign oLCD_StrataFlashControl = 1'b1;
  assign oBusy                   = oLCD_ReadWrite;
  assign oDone                   = (state == sDone);

endmodule

// File: tb/tb_lcd_nibble_reader.sv
// tb/tb_lcd_nibble_reader.sv - directed table-driven bench for lcd_nibble_reader
module tb_lcd_nibble_reader;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iRequest = 1'b0;
  logic       iRegisterSelect = 1'b0;
  logic       iPoll_Busy = 1'b0;
  logic [3:0] iLCD_Data = 4'h0;
  logic       oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite, oLCD_StrataFlashControl;
  logic [7:0] oData;
  logic       oDone, oBusy, oTimeout;

  int compared = 0;
  int mismatched = 0;

  lcd_nibble_reader #(.POLL_LIMIT(4)) dut (
    .Clock(Clock), .Reset(Reset), .iRequest(iRequest),
    .iRegisterSelect(iRegisterSelect), .iPoll_Busy(iPoll_Busy), .iLCD_Data(iLCD_Data),
    .oLCD_Enabled(oLCD_Enabled), .oLCD_RegisterSelect(oLCD_RegisterSelect),
    .oLCD_ReadWrite(oLCD_ReadWrite), .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
    .oData(oData), .oDone(oDone), .oBusy(oBusy), .oTimeout(oTimeout)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        rs;
    logic        poll;
    logic [31:0] bytes;
    int          reads;
    logic [7:0]  expData;
    logic        expTimeout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse a request at a falling edge; the next rising edge is acceptance edge k
  task automatic acceptReq(input logic rs, input logic poll);
    @(negedge Clock);
    iRegisterSelect = rs;
    iPoll_Busy = poll;
    iRequest = 1'b1;
    @(posedge Clock);
    #1 iRequest = 1'b0;
  endtask

  task automatic runRead(input vec_t v);
    int doneN, errE, errRw, errRs, errBusy, errDone;
    logic expRw, expE;
    logic [7:0] b;
    doneN = 3 + 124 * v.reads;
    errE = 0; errRw = 0; errRs = 0; errBusy = 0; errDone = 0;
    acceptReq(v.rs, v.poll);
    iRegisterSelect = ~v.rs;
    iPoll_Busy = ~v.poll;
    for (int n = 1; n <= doneN + 1; n++) begin
      @(negedge Clock);
      expRw = (n >= 1) && (n <= doneN - 1);
      expE = (n >= 3) && (n < doneN) &&
             (((n - 3) % 124 < 12) || ((n - 3) % 124 >= 62 && (n - 3) % 124 < 74));
      if (oLCD_Enabled !== expE) errE++;
      if (oLCD_ReadWrite !== expRw) errRw++;
      if (oLCD_RegisterSelect !== (expRw && v.rs && !v.poll)) errRs++;
      if (oBusy !== expRw) errBusy++;
      if (oDone !== (n == doneN)) errDone++;
      if (n == 1) check("timeoutClearedOnAccept", int'(oTimeout), 0);
      if (n == doneN) begin
        check("dataAtDone", int'(oData), int'(v.expData));
        check("timeoutAtDone", int'(oTimeout), int'(v.expTimeout));
      end
      if (n >= 3 && (n - 3) / 124 < 4) begin
        b = v.bytes[31 - 8 * ((n - 3) / 124) -: 8];
        iLCD_Data = ((n - 3) % 124 < 62) ? b[7:4] : b[3:0];
      end
    end
    check("ePattern", errE, 0);
    check("rwPattern", errRw, 0);
    check("rsPattern", errRs, 0);
    check("busyPattern", errBusy, 0);
    check("donePattern", errDone, 0);
    check("timeoutHeld", int'(oTimeout), int'(v.expTimeout));
  endtask

  initial begin
    int errBusy;
    vecs[0] = '{1'b1, 1'b0, 32'hA5000000, 1, 8'hA5, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h83000000, 1, 8'h83, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h9FC38012, 4, 8'h12, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h80808080, 4, 8'h80, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 32'hF0000000, 1, 8'hF0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h3C000000, 1, 8'h3C, 1'b0};

    #12;
    check("rstE", int'(oLCD_Enabled), 0);
    check("rstRw", int'(oLCD_ReadWrite), 0);
    check("rstData", int'(oData), 0);
    check("rstBusy", int'(oBusy), 0);
    check("sfControl", int'(oLCD_StrataFlashControl), 1);
    @(negedge Clock);
    Reset = 1'b0;

    for (int i = 0; i < 6; i++) runRead(vecs[i]);

    // Asynchronous reset in the middle of the first E pulse
    acceptReq(1'b1, 1'b0);
    repeat (8) @(negedge Clock);
    check("preResetE", int'(oLCD_Enabled), 1);
    Reset = 1'b1;
    #1;
    check("midResetE", int'(oLCD_Enabled), 0);
    check("midResetRw", int'(oLCD_ReadWrite), 0);
    check("midResetRs", int'(oLCD_RegisterSelect), 0);
    check("midResetBusy", int'(oBusy), 0);
    check("midResetData", int'(oData), 0);
    @(negedge Clock);
    Reset = 1'b0;
    runRead(vecs[0]);

    // Held request: re-accepted only after DONE and IDLE
    iLCD_Data = 4'h0;
    acceptReq(1'b0, 1'b0);
    iRequest = 1'b1;
    errBusy = 0;
    for (int n = 1; n <= 129; n++) begin
      @(negedge Clock);
      if (oBusy !== (n <= 126 || n == 129)) errBusy++;
      if (n == 127) check("heldDone", int'(oDone), 1);
    end
    check("heldBusyPattern", errBusy, 0);
    iRequest = 1'b0;
    // n = 129 is cycle 1 of the second transaction; pulse at its cycle 50
    for (int n = 2; n <= 135; n++) begin
      @(negedge Clock);
      iRequest = (n == 50);
      if (n == 127) check("secondDone", int'(oDone), 1);
    end
    iRequest = 1'b0;
    check("pulseIgnored", int'(oBusy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_reader.md
# lcd_nibble_reader

Read-side companion to the LCD command/data writer. Performs HD44780-style 4-bit read cycles on the Spartan-3E character LCD: busy-flag/address reads (RS=0) and DDRAM/CGRAM data reads (RS=1). It optionally polls the busy flag until it clears. It shares the LCD control pins with the writer through top-level muxing, and the top level releases SF_D<11:8> to input while `oBusy` is high.

## Interface
- `SETUP_CYCLES`, 2: RS/RW setup before the first E rise.
- `E_HIGH_CYCLES`, 12: E high width per nibble.
- `NIBBLE_GAP_CYCLES`, 50: E low time after each nibble (1 µs at 50 MHz).
- `POLL_LIMIT`, 1000: maximum busy-flag reads in poll mode, 1..65535.

Ports:
- `Clock` in 1: 50 MHz system clock.
- `Reset` in 1: asynchronous, active-high.
- `iRequest` in 1: start a read; sampled only in IDLE.
- `iRegisterSelect` in 1: 0 = busy flag/address, 1 = data. Latched at acceptance.
- `iPoll_Busy` in 1: poll mode. Latched at acceptance; forces RS=0.
- `iLCD_Data` in 4: SF_D<11:8> from the LCD.
- `oLCD_Enabled` out 1: LCD E.
- `oLCD_RegisterSelect` out 1: LCD RS.
- `oLCD_ReadWrite` out 1: LCD RW, 1 = read.
- `oLCD_StrataFlashControl` out 1: constant 1.
- `oData` out 8: assembled byte, high nibble first.
- `oDone` out 1: one-cycle completion pulse.
- `oBusy` out 1: high from acceptance until DONE.
- `oTimeout` out 1: poll limit reached with BF still 1. Valid with `oDone`; held until next acceptance.

## Operation
- States: IDLE, SETUP, EH1, GAP1, EH2, GAP2, DONE. All outputs are registered or decoded from the registered state, so E is glitch-free.
- IDLE: E=0, RW=0, RS=0. If `iRequest`=1, latch RS (0 if poll) and poll mode, clear the poll counter and `oTimeout`, then go to SETUP.
- SETUP: RW=1, RS=latched, E=0. Lasts SETUP_CYCLES, then EH1.
- EH1: E=1 for E_HIGH_CYCLES. On the clock edge ending the last EH1 cycle, capture `iLCD_Data` into `oData[7:4]`, then go to GAP1.
- GAP1: E=0 for NIBBLE_GAP_CYCLES, then EH2.
- EH2: same as EH1, but the capture goes into `oData[3:0]`.
- GAP2: E=0 for NIBBLE_GAP_CYCLES. Increment the poll counter on entry. On exit:
  - If poll mode, `oData[7]`=1, and counter < POLL_LIMIT: go to EH1. RS/RW stay held; no new SETUP.
  - If poll mode, `oData[7]`=1, and counter = POLL_LIMIT: set `oTimeout`, go to DONE.
  - Otherwise go to DONE.
- DONE: `oDone`=1 and `oBusy`=0 for one cycle, RW=0, then IDLE. `iRequest` is ignored in DONE.
- `iRequest` is ignored in every state except IDLE. Input changes after acceptance have no effect.
- `oData` holds its value until overwritten by the next capture.
- Phase counter is 16 bits and reloads on every state change. Poll counter is 16 bits and saturates at POLL_LIMIT.
- Reset (any time, including mid-E-pulse), asynchronously: state=IDLE, E=0, RW=0, RS=0, `oData`=0x00, `oDone`=0, `oBusy`=0, `oTimeout`=0, counters=0. `oLCD_StrataFlashControl`=1 always.

## Timing
- Acceptance at edge k (IDLE→SETUP). With defaults:
  - SETUP: cycles k+1..k+2.
  - EH1: k+3..k+14.
  - GAP1: k+15..k+64.
  - EH2: k+65..k+76.
  - GAP2: k+77..k+126.
  - DONE: k+127.
- Single read latency: 1 + SETUP + 2·(E_HIGH + GAP) cycles = 127 with defaults.
- Each additional poll read adds 2·(E_HIGH + GAP) = 124 cycles. N reads complete with DONE at k+3+124·N.
- Nibble capture is at the end of E high: 240 ns after E rise, beyond tDDR of 160 ns.
- RW falls at DONE, at least 1 µs after the last E fall.
- Minimum spacing between acceptances: 128 cycles, since DONE and IDLE each take one cycle.

## Test plan
- RS=1 read, bus 0xA during EH1 and 0x5 during EH2 → `oData`=0xA5 and `oDone` at k+127. E is high exactly 12 cycles twice. RW=1 over k+1..k+126. RS=1.
- RS=0 read, bus 0x8 then 0x3 → `oData`=0x83, RS=0 throughout, `oTimeout`=0.
- Poll with `iRegisterSelect`=1, BF=1 for 3 reads then a 4th read returning 0x12 → RS=0, four E-pulse pairs, `oDone` at k+499, `oData`=0x12, `oTimeout`=0.
- Poll with POLL_LIMIT=4 and the bus stuck at 0x8/0x0 → `oTimeout`=1 with `oDone` at k+499, `oData`=0x80.
- Reset asserted at k+8 (mid-EH1) → E, RW, RS, `oBusy` all 0 immediately and `oData`=0x00. A subsequent request completes normally in 127 cycles.
- `iRequest` held high continuously → accepted at k, ignored at k+1..k+127, re-accepted at k+128. A one-cycle pulse at k+50 is ignored.
